inf_nan_class_pipe: RTL and testbench

//  Multi-lane, registered IEEE-754 operand classifier with valid/ready flow control.

---
 rtl/fp_cls_pkg.sv | 31 +++
 rtl/inf_nan_class_pipe_if.sv | 28 ++
 rtl/fp_lane_cls.sv | 41 ++++
 rtl/inf_nan_class_pipe.sv | 101 ++++++++++
 tb/tb_inf_nan_class_pipe.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fp_cls_pkg.sv
// Shared floating-point class definitions: fclass-ordered one-hot bit indices
// and the saturating adder used by the status counters.
package fp_cls_pkg;

    localparam int CLS_W       = 10;
    localparam int CLS_NEG_INF = 0;
    localparam int CLS_NEG_NRM = 1;
    localparam int CLS_NEG_SUB = 2;
    localparam int CLS_NEG_ZER = 3;
    localparam int CLS_POS_ZER = 4;
    localparam int CLS_POS_SUB = 5;
    localparam int CLS_POS_NRM = 6;
    localparam int CLS_POS_INF = 7;
    localparam int CLS_SNAN    = 8;
    localparam int CLS_QNAN    = 9;

    // Counters up to SAT_W-1 bits wide; the extra carry bit means the sum never wraps.
    localparam int SAT_W = 32;

    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] cnt,
                                                 input logic [SAT_W-1:0] inc,
                                                 input int unsigned      cnt_w);
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, cnt} + {1'b0, inc};
        lim = ({{SAT_W{1'b0}}, 1'b1} << cnt_w) - 1'b1;
        if (sum > lim) sum = lim;
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/inf_nan_class_pipe_if.sv
// Input/output beat bus of the classifier pipe.
interface inf_nan_class_pipe_if
    import fp_cls_pkg::*;
#(
    parameter int LANES = 4,
    parameter int FP_W  = 32
);
    // A beat moves on a rising edge where vld && rdy; vld must not depend on rdy,
    // and data/cls are only meaningful while the matching vld is high.
    logic                   in_vld;
    logic                   in_rdy;
    logic [LANES*FP_W-1:0]  in_data;
    logic                   out_vld;
    logic                   out_rdy;
    logic [LANES*CLS_W-1:0] out_cls;
    logic                   out_any_nan;

    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_cls, out_any_nan
    );

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_cls, out_any_nan
    );

endinterface

// File: rtl/fp_lane_cls.sv
// Combinational single-operand classifier producing a one-hot fclass vector.
module fp_lane_cls
    import fp_cls_pkg::*;
#(
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic [EXPO_W+MANT_W:0] fp,
    output logic [CLS_W-1:0]       cls
);

    logic              sign;
    logic [EXPO_W-1:0] expo;
    logic [MANT_W-1:0] mant;
    logic              expo_max;
    logic              expo_zero;
    logic              mant_zero;

    assign sign      = fp[EXPO_W+MANT_W];
    assign expo      = fp[MANT_W +: EXPO_W];
    assign mant      = fp[MANT_W-1:0];
    assign expo_max  = &expo;
    assign expo_zero = ~|expo;
    assign mant_zero = ~|mant;

    // NaN classes are sign-agnostic; the mantissa MSB separates quiet from signalling.
    always_comb begin
        cls = '0;
        if (expo_max) begin
            if (mant_zero)             cls[sign ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
            else if (mant[MANT_W-1])   cls[CLS_QNAN] = 1'b1;
            else                       cls[CLS_SNAN] = 1'b1;
        end else if (expo_zero) begin
            if (mant_zero)             cls[sign ? CLS_NEG_ZER : CLS_POS_ZER] = 1'b1;
            else                       cls[sign ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
        end else begin
            cls[sign ? CLS_NEG_NRM : CLS_POS_NRM] = 1'b1;
        end
    end

endmodule

// File: rtl/inf_nan_class_pipe.sv
// Multi-lane registered IEEE-754 classifier with valid/ready flow control,
// sticky inf/nan/snan flags and saturating inf/NaN lane counters.
module inf_nan_class_pipe
    import fp_cls_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inf_nan_class_pipe_if.slave  bus,
    input  logic                 clr,
    output logic                 sticky_inf,
    output logic                 sticky_nan,
    output logic                 sticky_snan,
    output logic [CNT_W-1:0]     inf_cnt,
    output logic [CNT_W-1:0]     nan_cnt
);

    localparam int FP_W  = SIGN_W + EXPO_W + MANT_W;
    localparam int POP_W = $clog2(LANES + 1);

    logic [LANES*CLS_W-1:0] cls_d;
    logic [POP_W-1:0]       inf_pop;
    logic [POP_W-1:0]       nan_pop;
    logic                   any_inf;
    logic                   any_nan;
    logic                   any_snan;
    logic                   accept;
    logic [POP_W-1:0]       inf_inc;
    logic [POP_W-1:0]       nan_inc;
    logic [CNT_W-1:0]       inf_base;
    logic [CNT_W-1:0]       nan_base;
    logic [CNT_W-1:0]       inf_nxt;
    logic [CNT_W-1:0]       nan_nxt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_lane_cls #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_lane (
            .fp  (bus.in_data[i*FP_W +: FP_W]),
            .cls (cls_d[i*CLS_W +: CLS_W])
        );
    end

    always_comb begin
        inf_pop  = '0;
        nan_pop  = '0;
        any_snan = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            inf_pop  = inf_pop + POP_W'(cls_d[i*CLS_W + CLS_NEG_INF] | cls_d[i*CLS_W + CLS_POS_INF]);
            nan_pop  = nan_pop + POP_W'(cls_d[i*CLS_W + CLS_SNAN] | cls_d[i*CLS_W + CLS_QNAN]);
            any_snan = any_snan | cls_d[i*CLS_W + CLS_SNAN];
        end
    end

    assign any_inf    = |inf_pop;
    assign any_nan    = |nan_pop;
    assign bus.in_rdy = !bus.out_vld || bus.out_rdy;
    assign accept     = bus.in_vld && bus.in_rdy;

    // clr restarts the statistics from zero, so this beat's contribution still lands.
    assign inf_inc  = accept ? inf_pop : '0;
    assign nan_inc  = accept ? nan_pop : '0;
    assign inf_base = clr ? '0 : inf_cnt;
    assign nan_base = clr ? '0 : nan_cnt;
    assign inf_nxt  = CNT_W'(sat_add(SAT_W'(inf_base), SAT_W'(inf_inc), CNT_W));
    assign nan_nxt  = CNT_W'(sat_add(SAT_W'(nan_base), SAT_W'(nan_inc), CNT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_vld     <= 1'b0;
            bus.out_cls     <= '0;
            bus.out_any_nan <= 1'b0;
        end else if (accept) begin
            bus.out_vld     <= 1'b1;
            bus.out_cls     <= cls_d;
            bus.out_any_nan <= any_nan;
        end else if (bus.out_rdy) begin
            bus.out_vld     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_inf  <= 1'b0;
            sticky_nan  <= 1'b0;
            sticky_snan <= 1'b0;
            inf_cnt     <= '0;
            nan_cnt     <= '0;
        end else begin
            sticky_inf  <= (sticky_inf  && !clr) || (accept && any_inf);
            sticky_nan  <= (sticky_nan  && !clr) || (accept && any_nan);
            sticky_snan <= (sticky_snan && !clr) || (accept && any_snan);
            inf_cnt     <= inf_nxt;
            nan_cnt     <= nan_nxt;
        end
    end

endmodule

// File: tb/tb_inf_nan_class_pipe.sv
// Randomized and directed bench for inf_nan_class_pipe against a queue/arithmetic model.
module tb_inf_nan_class_pipe;
    import fp_cls_pkg::*;

    localparam int LANES = 4;
    localparam int FP_W  = 32;
    localparam int W     = LANES*CLS_W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic        s_inf16, s_nan16, s_snan16, s_inf4, s_nan4, s_snan4;
    logic [15:0] inf_cnt16, nan_cnt16;
    logic [3:0]  inf_cnt4, nan_cnt4;

    inf_nan_class_pipe_if #(.LANES(LANES), .FP_W(FP_W)) if16 ();
    inf_nan_class_pipe_if #(.LANES(LANES), .FP_W(FP_W)) if4 ();
    assign if4.in_vld  = if16.in_vld;
    assign if4.in_data = if16.in_data;
    assign if4.out_rdy = if16.out_rdy;

    inf_nan_class_pipe #(.CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16), .clr(clr),
        .sticky_inf(s_inf16), .sticky_nan(s_nan16), .sticky_snan(s_snan16),
        .inf_cnt(inf_cnt16), .nan_cnt(nan_cnt16)
    );

    inf_nan_class_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4), .clr(clr),
        .sticky_inf(s_inf4), .sticky_nan(s_nan4), .sticky_snan(s_snan4),
        .inf_cnt(inf_cnt4), .nan_cnt(nan_cnt4)
    );

    always #5 clk = ~clk;

    // scoreboard and model state
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int tot_inf = 0, tot_nan = 0;
    bit m_inf = 0, m_nan = 0, m_snan = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cls_idx(input logic [31:0] x);
        int e, m;
        e = int'(x[30:23]);
        m = int'(x[22:0]);
        if (e == 255) begin
            if (m == 0) return x[31] ? 0 : 7;
            return (m >= (1 << 22)) ? 9 : 8;
        end
        if (e == 0) begin
            if (m == 0) return x[31] ? 3 : 4;
            return x[31] ? 2 : 5;
        end
        return x[31] ? 1 : 6;
    endfunction

    function automatic logic [31:0] rand_lane();
        logic [31:0] s;
        s = {$urandom_range(0, 1) == 1, 31'h0};
        case ($urandom_range(0, 6))
            0: return s | 32'h7F80_0000;
            1: return s | 32'h7FC0_0000 | ($urandom & 32'h003F_FFFF);
            2: return s | 32'h7F80_0000 | $urandom_range(1, 32'h003F_FFFF);
            3: return s;
            4: return s | $urandom_range(1, 32'h007F_FFFF);
            5: return s | ($urandom_range(1, 254) << 23) | ($urandom & 32'h007F_FFFF);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [127:0] rand_beat();
        logic [127:0] d;
        for (int i = 0; i < LANES; i++) d[i*32 +: 32] = rand_lane();
        return d;
    endfunction

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic check_stats();
        check("sticky_inf", 64'(s_inf16), 64'(m_inf));
        check("sticky_nan", 64'(s_nan16), 64'(m_nan));
        check("sticky_snan", 64'(s_snan16), 64'(m_snan));
        check("inf_cnt16", 64'(inf_cnt16), 64'(sat(tot_inf, 16)));
        check("nan_cnt16", 64'(nan_cnt16), 64'(sat(tot_nan, 16)));
        check("inf_cnt4", 64'(inf_cnt4), 64'(sat(tot_inf, 4)));
        check("nan_cnt4", 64'(nan_cnt4), 64'(sat(tot_nan, 4)));
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit vld, input logic [127:0] data, input bit ordy, input bit clr_i);
        bit acc;
        logic [W-1:0] e;
        int idx;
        if16.in_vld  = vld;
        if16.in_data = data;
        if16.out_rdy = ordy;
        clr = clr_i;
        #1;
        check("out_vld", 64'(if16.out_vld), 64'(exp_q.size() != 0));
        check("in_rdy", 64'(if16.in_rdy), 64'(exp_q.size() == 0 || ordy));
        if (exp_q.size() != 0) begin
            check("out_cls", 64'(if16.out_cls), 64'(exp_q[0][W-2:0]));
            check("out_any_nan", 64'(if16.out_any_nan), 64'(exp_q[0][W-1]));
        end
        acc = vld && (exp_q.size() == 0 || ordy);
        @(posedge clk);
        if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
        if (clr_i) begin
            tot_inf = 0; tot_nan = 0; m_inf = 0; m_nan = 0; m_snan = 0;
        end
        if (acc) begin
            e = '0;
            for (int i = 0; i < LANES; i++) begin
                idx = cls_idx(data[i*32 +: 32]);
                e[i*CLS_W + idx] = 1'b1;
                if (idx == 0 || idx == 7) begin tot_inf++; m_inf = 1; end
                if (idx >= 8) begin tot_nan++; m_nan = 1; e[W-1] = 1'b1; end
                if (idx == 8) m_snan = 1;
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        check_stats();
    endtask

    initial begin
        if16.in_vld = 1'b0;
        if16.in_data = '0;
        if16.out_rdy = 1'b0;
        #12;
        check("rst_out_vld", 64'(if16.out_vld), 64'd0);
        check("rst_out_cls", 64'(if16.out_cls), 64'd0);
        check("rst_any_nan", 64'(if16.out_any_nan), 64'd0);
        check_stats();
        @(negedge clk);
        rst_n = 1'b1;

        // special values, then ordinary values; one literal check on the first beat
        step(1, {32'h7F80_0001, 32'h7FC0_0000, 32'hFF80_0000, 32'h7F80_0000}, 1, 0);
        check("dir_cls0", 64'(if16.out_cls), 64'({10'h100, 10'h200, 10'h001, 10'h080}));
        step(1, {32'h3F80_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000}, 1, 0);
        check("dir_cls1", 64'(if16.out_cls), 64'({10'h040, 10'h020, 10'h008, 10'h010}));
        check("dir_cnt1", 64'(inf_cnt16), 64'd2);

        // 8-beat stream under a 1,0,0,1 backpressure pattern
        for (int i = 0; i < 8; i++) step(1, rand_beat(), (i % 4 == 0) || (i % 4 == 3), 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);

        // clear, then saturate the 4-bit counters with all-inf beats
        step(0, '0, 1, 1);
        check("clr_zero", 64'(inf_cnt4), 64'd0);
        for (int i = 0; i < 5; i++) step(1, {4{32'hFF80_0000}}, 1, 0);
        check("sat_inf4", 64'(inf_cnt4), 64'd15);

        // clr together with an accepted beat holding a single qNaN
        step(1, {32'h3F80_0000, 32'h4000_0000, 32'h7FC0_0001, 32'h0000_0000}, 1, 1);
        check("clr_nan", 64'(nan_cnt16), 64'd1);

        // random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, rand_beat(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0);

        // reset while a beat is waiting for out_rdy
        step(0, '0, 1, 0);
        step(1, rand_beat(), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_vld", 64'(if16.out_vld), 64'd0);
        exp_q.delete();
        tot_inf = 0; tot_nan = 0; m_inf = 0; m_nan = 0; m_snan = 0;
        check_stats();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
